alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Pipeline stage directly upstream of the ALU. It latches one decoded instruction per cycle, resolves operand A and operand B from the register file, the immediate, or in-flight results (EX/MEM forwarding), and presents registered `ax`, `bx`, `opcode` and a valid flag to the ALU. It detects load-use hazards, inserts bubbles, and supports stall and flush from the pipeline controller.

## Interface
- `REG_W`, default 4: register index width (16 registers; r0 reads as zero).
- `DATA_W`, default 32: operand width.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_opcode` in 4: ALU opcode.
- `in_areg` / `in_breg` / `in_dreg` in REG_W each: source A, source B, destination.
- `in_we` in 1: instruction writes `in_dreg`.
- `in_use_imm` in 1: B is taken from `in_imm` instead of `in_breg`.
- `in_imm` in DATA_W: already-extended immediate.
- `rf_a_data` / `rf_b_data` in DATA_W: register-file read data for `in_areg` / `in_breg`, same cycle.
- `ex_valid`, `ex_we`, `ex_is_load` in 1; `ex_dreg` in REG_W; `ex_result` in DATA_W: instruction currently in ALU/EX.
- `mem_valid`, `mem_we` in 1; `mem_dreg` in REG_W; `mem_result` in DATA_W: instruction in MEM, with load data resolved.
- `flush` in 1: discard the held and incoming instruction.
- `out_ready` in 1: ALU stage accepts.
- `out_valid` out 1; `ax`, `bx` out DATA_W; `opcode` out 4; `out_dreg` out REG_W; `out_we` out 1.
- `stall_count` out 16: saturating count of hazard bubbles.

## Operation
- One output register set: `out_valid`, `ax`, `bx`, `opcode`, `out_dreg`, `out_we`.
- Handshake: a transfer occurs when `in_valid && in_ready`. `in_ready = (!out_valid || out_ready) && !hazard`.
- Operand resolution for A, and for B when `!in_use_imm`, in priority order:
  - index 0 gives 0;
  - EX match (`ex_valid && ex_we && ex_dreg == idx`) gives `ex_result`;
  - MEM match gives `mem_result`;
  - otherwise rf data.
  - EX beats MEM when both match, because EX is the youngest writer.
- `hazard` = `in_valid && ex_valid && ex_is_load && ex_we && ex_dreg != 0` and `ex_dreg` equals a used source index (B is unused when `in_use_imm`).
- On hazard with `out_ready` asserted, load a bubble (`out_valid=0`, `out_we=0`) and increment `stall_count`, saturating at 0xFFFF.
- When `out_valid && !out_ready`, all outputs hold unchanged and forwarding is not re-evaluated.
- Arithmetic: none. Values pass through at full DATA_W with no truncation.

## Timing
- Latency 1 cycle: inputs accepted at edge N appear on outputs after edge N.
- Throughput 1 per cycle. Each load-use hazard costs exactly 1 bubble: on the next cycle the load has moved to MEM and forwards from MEM.
- Reset: `out_valid=0`, `ax=0`, `bx=0`, `opcode=0`, `out_dreg=0`, `out_we=0`, `stall_count=0`. Reset overrides `flush` and the handshake.
- `flush` (when not in reset) clears `out_valid` and `out_we` at the next edge, ignores any incoming instruction, and does not count as a stall. The data registers may keep stale values.
- Flush together with hazard: flush wins and there is no count.
- Reset mid-stall: the stall is abandoned and the counter is cleared.

## Configuration
- `ALU_OPERAND_FORWARDING_EN` defined: the EX/MEM forwarding described above is active.
- Undefined: no forwarding paths.
  - `hazard` is asserted whenever any valid, writing EX or MEM instruction targets a used non-zero source. This holds regardless of `ex_is_load`.
  - The stage stalls until the writer has left MEM; operands then come from the register file.
  - `stall_count` counts every bubble.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode localparams `OP_OR`…`OP_FPMULTS` (4'b0000–4'b1111);
  - `REG_W`, `DATA_W`;
  - `REG_ZERO = 0`.
- Sub-module `operand_fwd_mux`: one index plus the rf/EX/MEM inputs in, a resolved value plus a `needs_stall` flag out. It is instantiated twice, for A and B.

## Test plan
- After reset: all outputs are 0 and `in_ready=1`. Send `OP_ADD` with r1=5, r2=7 from the rf: the next cycle shows `ax=5`, `bx=7`, `opcode=4'b0011`, `out_valid=1`.
- EX forwarding: `ex_dreg=3`, `ex_result=0x1234`, rf r3=0, `in_areg=3` gives `ax=0x1234`. When MEM also targets r3 with 0x9999, `ax` stays 0x1234.
- Load-use (forwarding on): `ex_is_load`, `ex_dreg=4`, `in_breg=4` gives one bubble, `in_ready=0` for 1 cycle and `stall_count=1`. The next cycle takes `bx` from `mem_result`.
- r0 and immediate:
  - `in_areg=0` with EX writing r0=0xFFFF gives `ax=0`;
  - `in_use_imm=1`, `in_imm=0xFFFFFFF0` gives `bx=0xFFFFFFF0` with no hazard against `in_breg`.
- Back-pressure plus flush:
  - holding `out_ready=0` for 3 cycles leaves outputs stable;
  - asserting `flush` then gives `out_valid=0` at the next edge, and the incoming instruction is dropped.
- Without `ALU_OPERAND_FORWARDING_EN`: a plain ALU writer to r5 followed by a reader of r5 gives 2 bubbles, `stall_count=2`, and `ax` equal to the written-back rf value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath widths and the hard-wired zero register.
package cpu_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [3:0] REG_ZERO = 4'd0;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_OR     = 4'b0000;
  localparam alu_op_t OP_AND    = 4'b0001;
  localparam alu_op_t OP_XOR    = 4'b0010;
  localparam alu_op_t OP_ADD    = 4'b0011;
  localparam alu_op_t OP_SUB    = 4'b0100;
  localparam alu_op_t OP_SLT    = 4'b0101;
  localparam alu_op_t OP_SLL    = 4'b0110;
  localparam alu_op_t OP_SRL    = 4'b0111;
  localparam alu_op_t OP_SRA    = 4'b1000;
  localparam alu_op_t OP_MUL    = 4'b1001;
  localparam alu_op_t OP_MULH   = 4'b1010;
  localparam alu_op_t OP_DIV    = 4'b1011;
  localparam alu_op_t OP_REM    = 4'b1100;
  localparam alu_op_t OP_FPADDS = 4'b1101;
  localparam alu_op_t OP_FPSUBS = 4'b1110;
  localparam alu_op_t OP_FPMULTS = 4'b1111;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decoded-instruction input bus and ALU-facing output bus of the operand stage.
interface alu_operand_stage_if #(
  parameter int REG_W  = cpu_pkg::REG_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [REG_W-1:0]  in_areg;
  logic [REG_W-1:0]  in_breg;
  logic [REG_W-1:0]  in_dreg;
  logic              in_we;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] ax;
  logic [DATA_W-1:0] bx;
  logic [3:0]        opcode;
  logic [REG_W-1:0]  out_dreg;
  logic              out_we;

  modport master (
    output in_valid, in_opcode, in_areg, in_breg, in_dreg, in_we, in_use_imm, in_imm, out_ready,
    input  in_ready, out_valid, ax, bx, opcode, out_dreg, out_we
  );

  modport slave (
    input  in_valid, in_opcode, in_areg, in_breg, in_dreg, in_we, in_use_imm, in_imm, out_ready,
    output in_ready, out_valid, ax, bx, opcode, out_dreg, out_we
  );
endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand from rf / EX / MEM and flags when it cannot be resolved yet.
// ALU_OPERAND_FORWARDING_EN selects forwarding; otherwise any pending writer stalls.
module operand_fwd_mux #(
  parameter int REG_W  = cpu_pkg::REG_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [REG_W-1:0]  idx,
  input  logic              used,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_dreg,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_dreg,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] value,
  output logic              needs_stall
);
  import cpu_pkg::*;

  logic nonzero_s;
  logic ex_hit_s;
  logic mem_hit_s;

  assign nonzero_s = (idx != REG_W'(REG_ZERO));
  assign ex_hit_s  = ex_valid && ex_we && (ex_dreg == idx) && nonzero_s;
  assign mem_hit_s = mem_valid && mem_we && (mem_dreg == idx) && nonzero_s;

`ifdef ALU_OPERAND_FORWARDING_EN
  // EX is the youngest writer, so it wins over MEM; a load in EX has no data yet.
  always_comb begin
    value       = rf_data;
    needs_stall = used && ex_hit_s && ex_is_load;
    if (!nonzero_s) begin
      value = {DATA_W{1'b0}};
    end else if (ex_hit_s) begin
      value = ex_result;
    end else if (mem_hit_s) begin
      value = mem_result;
    end else begin
      value = rf_data;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{ex_is_load, ex_result, mem_result};

  // Without bypass paths, wait until every pending writer has retired to the rf.
  always_comb begin
    value       = rf_data;
    needs_stall = used && (ex_hit_s || mem_hit_s);
    if (!nonzero_s) begin
      value = {DATA_W{1'b0}};
    end else begin
      value = rf_data;
    end
  end
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: operand resolution, load-use/RAW bubbles, stall and flush.
// ALU_OPERAND_FORWARDING_EN enables EX/MEM forwarding in operand_fwd_mux.
module alu_operand_stage #(
  parameter int REG_W  = cpu_pkg::REG_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  alu_operand_stage_if.slave bus,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  ex_dreg,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_dreg,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic [15:0]       stall_count
);
  logic [DATA_W-1:0] a_val_s;
  logic [DATA_W-1:0] b_val_s;
  logic              a_stall_s;
  logic              b_stall_s;
  logic              hazard_s;
  logic              advance_s;

  logic              out_valid_r;
  logic              out_we_r;
  logic [DATA_W-1:0] ax_r;
  logic [DATA_W-1:0] bx_r;
  logic [3:0]        opcode_r;
  logic [REG_W-1:0]  out_dreg_r;
  logic [15:0]       stall_count_r;

  operand_fwd_mux #(.REG_W(REG_W), .DATA_W(DATA_W)) u_mux_a (
    .idx(bus.in_areg), .used(1'b1), .rf_data(rf_a_data),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dreg(ex_dreg), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_dreg(mem_dreg), .mem_result(mem_result),
    .value(a_val_s), .needs_stall(a_stall_s)
  );

  operand_fwd_mux #(.REG_W(REG_W), .DATA_W(DATA_W)) u_mux_b (
    .idx(bus.in_breg), .used(!bus.in_use_imm), .rf_data(rf_b_data),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dreg(ex_dreg), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_dreg(mem_dreg), .mem_result(mem_result),
    .value(b_val_s), .needs_stall(b_stall_s)
  );

  assign hazard_s     = bus.in_valid && (a_stall_s || b_stall_s);
  assign advance_s    = !out_valid_r || bus.out_ready;
  assign bus.in_ready = advance_s && !hazard_s;

  // Output register: reset beats flush, flush beats the handshake; held data is frozen under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r   <= 1'b0;
      out_we_r      <= 1'b0;
      ax_r          <= {DATA_W{1'b0}};
      bx_r          <= {DATA_W{1'b0}};
      opcode_r      <= 4'd0;
      out_dreg_r    <= {REG_W{1'b0}};
      stall_count_r <= 16'd0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      out_we_r    <= 1'b0;
    end else begin
      if (hazard_s && bus.out_ready && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
      if (advance_s) begin
        if (bus.in_valid && !hazard_s) begin
          out_valid_r <= 1'b1;
          out_we_r    <= bus.in_we;
          ax_r        <= a_val_s;
          bx_r        <= bus.in_use_imm ? bus.in_imm : b_val_s;
          opcode_r    <= bus.in_opcode;
          out_dreg_r  <= bus.in_dreg;
        end else begin
          out_valid_r <= 1'b0;
          out_we_r    <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_we    = out_we_r;
  assign bus.ax        = ax_r;
  assign bus.bx        = bx_r;
  assign bus.opcode    = opcode_r;
  assign bus.out_dreg  = out_dreg_r;
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic against a behavioural model.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  localparam int RW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] rf_a_data, rf_b_data;
  logic          ex_valid, ex_we, ex_is_load;
  logic [RW-1:0] ex_dreg;
  logic [DW-1:0] ex_result;
  logic          mem_valid, mem_we;
  logic [RW-1:0] mem_dreg;
  logic [DW-1:0] mem_result;
  logic          flush;
  logic [15:0]   stall_count;

  alu_operand_stage_if #(.REG_W(RW), .DATA_W(DW)) bus ();

  alu_operand_stage #(.REG_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_dreg(ex_dreg), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_dreg(mem_dreg), .mem_result(mem_result),
    .flush(flush), .stall_count(stall_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Expected state of the stage's outputs.
  logic          e_valid, e_we;
  logic [DW-1:0] e_ax, e_bx;
  logic [3:0]    e_op;
  logic [RW-1:0] e_dreg;
  logic [15:0]   e_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit writes(input logic v, input logic we, input logic [RW-1:0] d, input logic [RW-1:0] idx);
    return v && we && (d == idx) && (idx != 4'd0);
  endfunction

  function automatic logic [DW-1:0] resolve(input logic [RW-1:0] idx, input logic [DW-1:0] rf);
    if (idx == 4'd0) return 32'd0;
`ifdef ALU_OPERAND_FORWARDING_EN
    if (writes(ex_valid, ex_we, ex_dreg, idx)) return ex_result;
    if (writes(mem_valid, mem_we, mem_dreg, idx)) return mem_result;
`endif
    return rf;
  endfunction

  function automatic bit src_blocked(input logic [RW-1:0] idx);
`ifdef ALU_OPERAND_FORWARDING_EN
    return ex_is_load && writes(ex_valid, ex_we, ex_dreg, idx);
`else
    return writes(ex_valid, ex_we, ex_dreg, idx) || writes(mem_valid, mem_we, mem_dreg, idx);
`endif
  endfunction

  function automatic bit model_hazard();
    bit h;
    h = src_blocked(bus.in_areg);
    if (!bus.in_use_imm) h = h || src_blocked(bus.in_breg);
    return bus.in_valid && h;
  endfunction

  task automatic model_step();
    bit haz, adv;
    if (reset) begin
      e_valid = 1'b0; e_we = 1'b0; e_ax = 32'd0; e_bx = 32'd0;
      e_op = 4'd0; e_dreg = 4'd0; e_cnt = 16'd0;
    end else if (flush) begin
      e_valid = 1'b0; e_we = 1'b0;
    end else begin
      haz = model_hazard();
      adv = !e_valid || bus.out_ready;
      if (haz && bus.out_ready && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      if (adv) begin
        if (bus.in_valid && !haz) begin
          e_valid = 1'b1;
          e_we    = bus.in_we;
          e_op    = bus.in_opcode;
          e_dreg  = bus.in_dreg;
          e_ax    = resolve(bus.in_areg, rf_a_data);
          e_bx    = bus.in_use_imm ? bus.in_imm : resolve(bus.in_breg, rf_b_data);
        end else begin
          e_valid = 1'b0; e_we = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", bus.out_valid, e_valid);
    check("out_we", bus.out_we, e_we);
    check("stall_count", stall_count, e_cnt);
    check("in_ready", bus.in_ready, (!e_valid || bus.out_ready) && !model_hazard());
    if (e_valid) begin
      check("ax", bus.ax, e_ax);
      check("bx", bus.bx, e_bx);
      check("opcode", bus.opcode, e_op);
      check("out_dreg", bus.out_dreg, e_dreg);
    end
  endtask

  // One clock: model update at the edge, full comparison on the falling edge, then new inputs may be driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic clear_fwd();
    ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_dreg = 4'd0; ex_result = 32'd0;
    mem_valid = 1'b0; mem_we = 1'b0; mem_dreg = 4'd0; mem_result = 32'd0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                       input logic [RW-1:0] d, input logic we, input logic imm_sel,
                       input logic [DW-1:0] imm, input logic [DW-1:0] rfa, input logic [DW-1:0] rfb);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_areg = a; bus.in_breg = b; bus.in_dreg = d;
    bus.in_we = we; bus.in_use_imm = imm_sel; bus.in_imm = imm; rf_a_data = rfa; rf_b_data = rfb;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; bus.out_ready = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = 4'd0; bus.in_areg = 4'd0; bus.in_breg = 4'd0; bus.in_dreg = 4'd0;
    bus.in_we = 1'b0; bus.in_use_imm = 1'b0; bus.in_imm = 32'd0; rf_a_data = 32'd0; rf_b_data = 32'd0;
    clear_fwd();
    repeat (2) tick();
    reset = 1'b0;

    check("rst out_valid", bus.out_valid, 32'd0);
    check("rst ax", bus.ax, 32'd0);
    check("rst bx", bus.bx, 32'd0);
    check("rst opcode", bus.opcode, 32'd0);
    check("rst out_dreg", bus.out_dreg, 32'd0);
    check("rst out_we", bus.out_we, 32'd0);
    check("rst stall_count", stall_count, 32'd0);
    check("rst in_ready", bus.in_ready, 32'd1);

    // Plain rf operands.
    instr(OP_ADD, 4'd1, 4'd2, 4'd6, 1'b1, 1'b0, 32'd0, 32'd5, 32'd7);
    tick();
    check("add ax", bus.ax, 32'd5);
    check("add bx", bus.bx, 32'd7);
    check("add opcode", bus.opcode, 32'b0011);
    check("add out_valid", bus.out_valid, 32'd1);

`ifdef ALU_OPERAND_FORWARDING_EN
    instr(OP_SUB, 4'd3, 4'd1, 4'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'h10);
    ex_valid = 1'b1; ex_we = 1'b1; ex_dreg = 4'd3; ex_result = 32'h1234;
    tick();
    check("ex fwd ax", bus.ax, 32'h1234);
    check("ex fwd bx", bus.bx, 32'h10);
    mem_valid = 1'b1; mem_we = 1'b1; mem_dreg = 4'd3; mem_result = 32'h9999;
    tick();
    check("ex over mem ax", bus.ax, 32'h1234);

    clear_fwd();
    instr(OP_ADD, 4'd1, 4'd4, 4'd8, 1'b1, 1'b0, 32'd0, 32'h21, 32'd0);
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_dreg = 4'd4; ex_result = 32'hDEAD;
    #1 check("load-use in_ready", bus.in_ready, 32'd0);
    tick();
    check("load-use bubble", bus.out_valid, 32'd0);
    check("load-use count", stall_count, 32'd1);
    clear_fwd();
    mem_valid = 1'b1; mem_we = 1'b1; mem_dreg = 4'd4; mem_result = 32'hABCD;
    #1 check("load-use resume ready", bus.in_ready, 32'd1);
    tick();
    check("load-use mem bx", bus.bx, 32'hABCD);
    check("load-use ax", bus.ax, 32'h21);
    check("load-use count hold", stall_count, 32'd1);
`endif

    // r0 is always zero; an immediate B never hazards on in_breg.
    clear_fwd();
    instr(OP_OR, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, 32'd0, 32'h77, 32'h3);
    ex_valid = 1'b1; ex_we = 1'b1; ex_dreg = 4'd0; ex_result = 32'hFFFF;
    tick();
    check("r0 ax", bus.ax, 32'd0);
    check("r0 bx", bus.bx, 32'h3);
    clear_fwd();
    instr(OP_FPADDS, 4'd1, 4'd5, 4'd2, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h9, 32'h55);
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_dreg = 4'd5;
    #1 check("imm in_ready", bus.in_ready, 32'd1);
    tick();
    check("imm bx", bus.bx, 32'hFFFFFFF0);
    check("imm ax", bus.ax, 32'h9);

    // Back-pressure holds the outputs, then flush drops the pending instruction.
    clear_fwd();
    instr(OP_XOR, 4'd2, 4'd3, 4'd9, 1'b1, 1'b0, 32'd0, 32'hAAAA0001, 32'h55550002);
    tick();
    bus.out_ready = 1'b0;
    instr(OP_SUB, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0, 32'd0, 32'h1, 32'h1);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp in_ready", bus.in_ready, 32'd0);
      tick();
      check("bp ax", bus.ax, 32'hAAAA0001);
      check("bp bx", bus.bx, 32'h55550002);
      check("bp opcode", bus.opcode, 32'b0010);
      check("bp out_dreg", bus.out_dreg, 32'd9);
      check("bp out_valid", bus.out_valid, 32'd1);
    end
    flush = 1'b1;
    tick();
    check("flush out_valid", bus.out_valid, 32'd0);
    check("flush out_we", bus.out_we, 32'd0);
    flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("flush dropped", bus.out_valid, 32'd0);

`ifndef ALU_OPERAND_FORWARDING_EN
    // Without bypass, a RAW dependency waits two bubbles for write-back.
    instr(OP_ADD, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0, 32'd0, 32'd1, 32'd2);
    tick();
    ex_valid = 1'b1; ex_we = 1'b1; ex_dreg = 4'd5; ex_result = 32'h55;
    instr(OP_ADD, 4'd5, 4'd0, 4'd6, 1'b1, 1'b0, 32'd0, 32'h11, 32'd0);
    #1 check("raw in_ready 1", bus.in_ready, 32'd0);
    tick();
    check("raw bubble 1", bus.out_valid, 32'd0);
    check("raw count 1", stall_count, 32'd1);
    clear_fwd();
    mem_valid = 1'b1; mem_we = 1'b1; mem_dreg = 4'd5; mem_result = 32'h55;
    #1 check("raw in_ready 2", bus.in_ready, 32'd0);
    tick();
    check("raw bubble 2", bus.out_valid, 32'd0);
    check("raw count 2", stall_count, 32'd2);
    clear_fwd();
    rf_a_data = 32'h55;
    #1 check("raw in_ready 3", bus.in_ready, 32'd1);
    tick();
    check("raw ax", bus.ax, 32'h55);
    check("raw out_valid", bus.out_valid, 32'd1);
    check("raw count final", stall_count, 32'd2);
`endif

    // Reset during a stall clears the counter.
    clear_fwd();
    instr(OP_AND, 4'd6, 4'd0, 4'd7, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_dreg = 4'd6;
    tick();
    check("pre-reset bubble", bus.out_valid, 32'd0);
    reset = 1'b1;
    tick();
    check("mid-stall reset count", stall_count, 32'd0);
    check("mid-stall reset valid", bus.out_valid, 32'd0);
    reset = 1'b0; clear_fwd(); bus.in_valid = 1'b0;
    tick();

    // Random traffic over a small register window to provoke frequent matches.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid   = ($urandom % 4) != 0;
      bus.in_opcode  = 4'($urandom);
      bus.in_areg    = 4'($urandom_range(0, 3));
      bus.in_breg    = 4'($urandom_range(0, 3));
      bus.in_dreg    = 4'($urandom_range(0, 3));
      bus.in_we      = 1'($urandom);
      bus.in_use_imm = ($urandom % 4) == 0;
      bus.in_imm     = $urandom;
      rf_a_data      = $urandom;
      rf_b_data      = $urandom;
      ex_valid       = 1'($urandom);
      ex_we          = 1'($urandom);
      ex_is_load     = 1'($urandom);
      ex_dreg        = 4'($urandom_range(0, 3));
      ex_result      = $urandom;
      mem_valid      = 1'($urandom);
      mem_we         = 1'($urandom);
      mem_dreg       = 4'($urandom_range(0, 3));
      mem_result     = $urandom;
      flush          = ($urandom % 16) == 0;
      bus.out_ready  = ($urandom % 4) != 0;
      reset          = ($urandom % 128) == 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
